// File: rtl/stream_pattern_match_pkg.sv
// Shared types and helpers for stream_pattern_match.
//   state_e   : controller states (idle / running a message stream)
//   pop_width : bits needed to hold a popcount of n flags (0..n)
package stream_pattern_match_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  function automatic int unsigned pop_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/window_compare.sv
// Compares one M-bit text window against the pattern.
// Ports:
//   i_window  : text bits, index 0 earliest in the stream
//   i_pattern : pattern bits, index 0 compared first
//   i_mask    : 1 = don't-care position
//   o_hit     : every non-masked position matches
module window_compare #(
  parameter int unsigned M = 4
) (
  input  logic [0:M-1] i_window,
  input  logic [0:M-1] i_pattern,
  input  logic [0:M-1] i_mask,
  output logic         o_hit
);

  assign o_hit = &(~(i_window ^ i_pattern) | i_mask);

endmodule

// File: rtl/stream_pattern_match.sv
// Streaming M-bit pattern matcher over W-bit beats with valid/ready on both sides.
// Matches straddling beat boundaries are found via an (M-1)-bit history of the
// current message; a saturating counter totals matches since the last load.
// Build option: define MATCH_WILDCARD_EN to honour the don't-care mask; otherwise
// the mask port is ignored and the compare is exact.
// Ports:
//   i_clock, i_reset          : clock, synchronous active-high reset
//   i_enable, i_load          : run request, pattern/mask capture pulse (idle only)
//   i_pattern, i_mask         : pattern and don't-care mask, index 0 earliest
//   i_in_valid/o_in_ready     : input handshake; i_in_data, i_in_last the beat
//   o_out_valid/i_out_ready   : output handshake; o_out_flag bit i = match ends at i
//   o_out_last                : in_last of the reported beat
//   o_match_count             : saturating match total since last load
//   o_busy                    : controller is running
module stream_pattern_match
  import stream_pattern_match_pkg::*;
#(
  parameter int unsigned M     = 4,
  parameter int unsigned W     = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_load,
  input  logic [0:M-1]     i_pattern,
  input  logic [0:M-1]     i_mask,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [0:W-1]     i_in_data,
  input  logic             i_in_last,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [0:W-1]     o_out_flag,
  output logic             o_out_last,
  output logic [CNT_W-1:0] o_match_count,
  output logic             o_busy
);

  localparam int unsigned HistW = $clog2(M);
  localparam int unsigned PopW  = pop_width(W);
  localparam logic [HistW-1:0] HistFull = HistW'(M - 1);

  state_e             r_state;
  logic               r_pat_loaded;
  logic [0:M-1]       r_pat;
  logic [0:M-2]       r_hist;
  logic [HistW-1:0]   r_hist_cnt;
  logic               r_out_valid;
  logic [0:W-1]       r_out_flag;
  logic               r_out_last;
  logic [CNT_W-1:0]   r_cnt;

  logic [0:M+W-2]     w_cat;
  logic [0:M-1]       w_msk;
  logic [0:W-1]       w_hit;
  logic [0:W-1]       w_elig;
  logic [0:W-1]       w_flag;
  logic [PopW-1:0]    w_pop;
  logic [CNT_W:0]     w_sum;
  logic [CNT_W-1:0]   w_cnt_next;
  logic               w_accept;

`ifdef MATCH_WILDCARD_EN
  logic [0:M-1] r_msk;
  assign w_msk = r_msk;
`else
  logic [0:M-1] w_unused_mask;
  assign w_unused_mask = i_mask;
  assign w_msk         = '0;
`endif

  assign o_in_ready = (r_state == StRun) && i_enable && (!r_out_valid || i_out_ready);
  assign w_accept   = i_in_valid && o_in_ready;

  // History sits in front of the beat so window ending at in_data[i] is w_cat[i +: M].
  assign w_cat = {r_hist, i_in_data};

  for (genvar gi = 0; gi < W; gi++) begin : g_pos
    window_compare #(
      .M(M)
    ) u_cmp (
      .i_window (w_cat[gi +: M]),
      .i_pattern(r_pat),
      .i_mask   (w_msk),
      .o_hit    (w_hit[gi])
    );
    // Eligible once M bits of this message exist: hist_cnt + i + 1 >= M.
    if (gi + 1 >= M) begin : g_full
      assign w_elig[gi] = 1'b1;
    end else begin : g_hist
      assign w_elig[gi] = (r_hist_cnt >= HistW'(M - 1 - gi));
    end
  end

  assign w_flag = w_hit & w_elig;

  always_comb begin
    w_pop = '0;
    for (int k = 0; k < W; k++) begin
      w_pop = w_pop + PopW'(w_flag[k]);
    end
  end

  assign w_sum      = {1'b0, r_cnt} + (CNT_W + 1)'(w_pop);
  assign w_cnt_next = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_pat_loaded <= 1'b0;
      r_pat        <= '0;
`ifdef MATCH_WILDCARD_EN
      r_msk        <= '0;
`endif
      r_hist       <= '0;
      r_hist_cnt   <= '0;
      r_out_valid  <= 1'b0;
      r_out_flag   <= '0;
      r_out_last   <= 1'b0;
      r_cnt        <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_flag  <= w_flag;
        r_out_last  <= i_in_last;
        r_cnt       <= w_cnt_next;
        if (i_in_last) begin
          r_hist     <= '0;
          r_hist_cnt <= '0;
        end else begin
          r_hist     <= i_in_data[W-M+1 +: M-1];
          // M <= W, so one beat always fills the history.
          r_hist_cnt <= HistFull;
        end
      end else if (r_out_valid && i_out_ready) begin
        r_out_valid <= 1'b0;
      end

      unique case (r_state)
        StIdle: begin
          if (i_load) begin
            r_pat        <= i_pattern;
`ifdef MATCH_WILDCARD_EN
            r_msk        <= i_mask;
`endif
            r_pat_loaded <= 1'b1;
            r_cnt        <= '0;
          end
          if (i_enable && r_pat_loaded) begin
            r_state <= StRun;
          end
        end
        StRun: begin
          // Leave only at a message boundary with the output drained.
          if (!i_enable && (r_hist_cnt == '0) && !r_out_valid) begin
            r_state <= StIdle;
          end
        end
      endcase
    end
  end

  assign o_out_valid   = r_out_valid;
  assign o_out_flag    = r_out_flag;
  assign o_out_last    = r_out_last;
  assign o_match_count = r_cnt;
  assign o_busy        = (r_state != StIdle);

endmodule

// File: tb/tb_stream_pattern_match.sv
module tb_stream_pattern_match;

  localparam int unsigned M     = 4;
  localparam int unsigned W     = 16;
  localparam int unsigned CNT_W = 16;

`ifdef MATCH_WILDCARD_EN
  localparam bit Wild = 1'b1;
`else
  localparam bit Wild = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             i_reset;
  logic             i_enable;
  logic             i_load;
  logic [0:M-1]     i_pattern;
  logic [0:M-1]     i_mask;
  logic             i_in_valid;
  logic             o_in_ready;
  logic [0:W-1]     i_in_data;
  logic             i_in_last;
  logic             o_out_valid;
  logic             i_out_ready;
  logic [0:W-1]     o_out_flag;
  logic             o_out_last;
  logic [CNT_W-1:0] o_match_count;
  logic             o_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stream_pattern_match #(
    .M(M),
    .W(W),
    .CNT_W(CNT_W)
  ) dut (
    .i_clock      (clk),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_load       (i_load),
    .i_pattern    (i_pattern),
    .i_mask       (i_mask),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .i_in_data    (i_in_data),
    .i_in_last    (i_in_last),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_out_flag   (o_out_flag),
    .o_out_last   (o_out_last),
    .o_match_count(o_match_count),
    .o_busy       (o_busy)
  );

  typedef struct {
    logic         ld;
    logic [0:M-1] pat;
    logic [0:M-1] msk;
    logic [0:W-1] data;
    logic         last;
    logic [0:W-1] flag;
    logic [15:0]  cnt;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_pat(input logic [0:M-1] p, input logic [0:M-1] m);
    i_enable = 1'b0;
    for (int k = 0; k < 20 && o_busy; k++) begin
      @(posedge clk);
      #1;
    end
    chk("reach_idle", 32'(o_busy), 32'd0);
    i_pattern = p;
    i_mask    = m;
    i_load    = 1'b1;
    @(posedge clk);
    #1;
    i_load   = 1'b0;
    i_enable = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [0:W-1] d, input logic l);
    i_in_data  = d;
    i_in_last  = l;
    i_in_valid = 1'b1;
    #1;
    for (int k = 0; k < 20 && !o_in_ready; k++) begin
      @(posedge clk);
      #1;
    end
    chk("in_ready_wait", 32'(o_in_ready), 32'd1);
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 4'b1111, 4'b0000, 16'hFFFF, 1'b1, 16'h1FFF, 16'd13};
    vecs[1] = '{1'b1, 4'b1011, 4'b0000, 16'h0005, 1'b0, 16'h0000, 16'd0};
    vecs[2] = '{1'b0, 4'b0000, 4'b0000, 16'h8000, 1'b1, 16'h8000, 16'd1};
    vecs[3] = '{1'b1, 4'b1011, 4'b0000, 16'h0005, 1'b1, 16'h0000, 16'd0};
    vecs[4] = '{1'b0, 4'b0000, 4'b0000, 16'h8000, 1'b1, 16'h0000, 16'd0};
    vecs[5] = '{1'b1, 4'b1111, 4'b0100, 16'hB000, 1'b1,
                Wild ? 16'h1000 : 16'h0000, Wild ? 16'd1 : 16'd0};
    vecs[6] = '{1'b1, 4'b0000, 4'b1111, 16'h1234, 1'b1,
                Wild ? 16'h1FFF : 16'h0000, Wild ? 16'd13 : 16'd0};
    vecs[7] = '{1'b1, 4'b1111, 4'b0000, 16'hFFFF, 1'b0, 16'h1FFF, 16'd13};
    vecs[8] = '{1'b0, 4'b0000, 4'b0000, 16'hFFFF, 1'b1, 16'hFFFF, 16'd29};
    vecs[9] = '{1'b1, 4'b1010, 4'b0000, 16'hAAAA, 1'b1, 16'h1555, 16'd7};

    i_reset     = 1'b1;
    i_enable    = 1'b0;
    i_load      = 1'b0;
    i_pattern   = '0;
    i_mask      = '0;
    i_in_valid  = 1'b0;
    i_in_data   = '0;
    i_in_last   = 1'b0;
    i_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b0;

    chk("rst_out_valid", 32'(o_out_valid), 32'd0);
    chk("rst_out_flag", 32'(o_out_flag), 32'd0);
    chk("rst_out_last", 32'(o_out_last), 32'd0);
    chk("rst_count", 32'(o_match_count), 32'd0);
    chk("rst_in_ready", 32'(o_in_ready), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);

    // Table-driven single-beat checks.
    for (int v = 0; v < 10; v++) begin
      if (vecs[v].ld) load_pat(vecs[v].pat, vecs[v].msk);
      send_beat(vecs[v].data, vecs[v].last);
      chk($sformatf("vec%0d_valid", v), 32'(o_out_valid), 32'd1);
      chk($sformatf("vec%0d_flag", v), 32'(o_out_flag), 32'(vecs[v].flag));
      chk($sformatf("vec%0d_last", v), 32'(o_out_last), 32'(vecs[v].last));
      chk($sformatf("vec%0d_count", v), 32'(o_match_count), 32'(vecs[v].cnt));
    end

    // Load pulsed in RUN is ignored; then backpressure holds the output.
    load_pat(4'b1111, 4'b0000);
    i_pattern = 4'b0000;
    i_load    = 1'b1;
    @(posedge clk);
    #1;
    i_load = 1'b0;
    send_beat(16'hFFFF, 1'b0);
    chk("bp_x_flag", 32'(o_out_flag), 32'h1FFF);
    chk("bp_x_count", 32'(o_match_count), 32'd13);
    i_out_ready = 1'b0;
    i_in_data   = 16'h000F;
    i_in_last   = 1'b1;
    i_in_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp_in_ready%0d", c), 32'(o_in_ready), 32'd0);
      chk($sformatf("bp_valid%0d", c), 32'(o_out_valid), 32'd1);
      chk($sformatf("bp_flag%0d", c), 32'(o_out_flag), 32'h1FFF);
      @(posedge clk);
      #1;
    end
    i_out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(o_in_ready), 32'd1);
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
    chk("bp_y_valid", 32'(o_out_valid), 32'd1);
    chk("bp_y_flag", 32'(o_out_flag), 32'h0001);
    chk("bp_y_last", 32'(o_out_last), 32'd1);
    chk("bp_y_count", 32'(o_match_count), 32'd14);
    @(posedge clk);
    #1;
    chk("bp_drained", 32'(o_out_valid), 32'd0);

    // Mid-message stall, then reset discards history and pattern.
    load_pat(4'b1011, 4'b0000);
    send_beat(16'h0005, 1'b0);
    send_beat(16'h8000, 1'b0);
    chk("mm_cross_flag", 32'(o_out_flag), 32'h8000);
    chk("mm_cross_count", 32'(o_match_count), 32'd1);
    send_beat(16'h0005, 1'b0);
    i_enable = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("stall_busy", 32'(o_busy), 32'd1);
    chk("stall_in_ready", 32'(o_in_ready), 32'd0);
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    i_reset = 1'b0;
    chk("mrst_valid", 32'(o_out_valid), 32'd0);
    chk("mrst_flag", 32'(o_out_flag), 32'd0);
    chk("mrst_last", 32'(o_out_last), 32'd0);
    chk("mrst_count", 32'(o_match_count), 32'd0);
    chk("mrst_busy", 32'(o_busy), 32'd0);
    i_enable = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("mrst_no_run", 32'(o_busy), 32'd0);
    chk("mrst_no_ready", 32'(o_in_ready), 32'd0);
    load_pat(4'b1011, 4'b0000);
    chk("reload_busy", 32'(o_busy), 32'd1);
    send_beat(16'h8000, 1'b1);
    chk("reload_flag", 32'(o_out_flag), 32'h0000);
    chk("reload_count", 32'(o_match_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
